// File: rtl/cache_ctrl_fsm_if.sv
// Shared types for the L1 command sequencer and its trace/array bus.
package cache_ctrl_pkg;

   localparam int unsigned SETS   = 16384;
   localparam int unsigned WAYS   = 8;
   localparam int unsigned TAG_W  = 12;
   localparam int unsigned SET_W  = $clog2(SETS);
   localparam int unsigned WAY_W  = $clog2(WAYS);
   localparam int unsigned LRU_W  = $clog2(WAYS);
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned OFF_W  = ADDR_W - TAG_W - SET_W;
   localparam int unsigned CMD_W  = 4;
   localparam int unsigned CNT_W  = 32;

   localparam logic [CMD_W-1:0] CMD_RD       = 4'd0;
   localparam logic [CMD_W-1:0] CMD_WR       = 4'd1;
   localparam logic [CMD_W-1:0] CMD_IFETCH   = 4'd2;
   localparam logic [CMD_W-1:0] CMD_SNP_RD   = 4'd3;
   localparam logic [CMD_W-1:0] CMD_SNP_WR   = 4'd4;
   localparam logic [CMD_W-1:0] CMD_SNP_RWIM = 4'd5;
   localparam logic [CMD_W-1:0] CMD_SNP_INV  = 4'd6;
   localparam logic [CMD_W-1:0] CMD_CLEAR    = 4'd8;
   localparam logic [CMD_W-1:0] CMD_PRINT    = 4'd9;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_READ  = 2'd1;
   localparam logic [1:0] BUS_RWIM  = 2'd2;
   localparam logic [1:0] BUS_INVAL = 2'd3;

   localparam logic [1:0] SNP_NOHIT = 2'd0;
   localparam logic [1:0] SNP_HIT   = 2'd1;
   localparam logic [1:0] SNP_HITM  = 2'd2;

   typedef enum logic [1:0] {
      MESI_I = 2'd0,
      MESI_S = 2'd1,
      MESI_E = 2'd2,
      MESI_M = 2'd3
   } mesi_t;

   typedef struct packed {
      mesi_t             mesi;
      logic [LRU_W-1:0]  lru;
      logic [TAG_W-1:0]  tag;
   } cache_line_t;

   typedef cache_line_t [WAYS-1:0] cache_set_t;

endpackage

// Command handshake, array access and statistics bundle.
interface cache_ctrl_if;
   import cache_ctrl_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [CMD_W-1:0]  cmd_n;
   logic [ADDR_W-1:0] cmd_addr;
   logic              rd_en;
   logic [SET_W-1:0]  rd_set;
   cache_set_t        line_in;
   logic              wr_en;
   cache_set_t        line_out;
   logic [1:0]        bus_op;
   logic              bus_shared;
   logic              writeback;
   logic [1:0]        snoop_res;
   logic              cmd_done;
   logic [CNT_W-1:0]  hit_cnt;
   logic [CNT_W-1:0]  miss_cnt;
   logic [CNT_W-1:0]  rd_cnt;
   logic [CNT_W-1:0]  wr_cnt;

   modport slave (
      input  cmd_valid, cmd_n, cmd_addr, line_in, bus_shared,
      output cmd_ready, rd_en, rd_set, wr_en, line_out, bus_op,
             writeback, snoop_res, cmd_done,
             hit_cnt, miss_cnt, rd_cnt, wr_cnt
   );

   modport master (
      output cmd_valid, cmd_n, cmd_addr, line_in, bus_shared,
      input  cmd_ready, rd_en, rd_set, wr_en, line_out, bus_op,
             writeback, snoop_res, cmd_done,
             hit_cnt, miss_cnt, rd_cnt, wr_cnt
   );

endinterface

// File: rtl/cache_ctrl_fsm.sv
// L1 command sequencer: read set, tag compare, MESI/LRU update, write set back.
module cache_ctrl_fsm
   import cache_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   cache_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_EVAL  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t state, next_state;

   // Latched command and evaluation result
   logic [CMD_W-1:0] cmd_q,  cmd_d;
   logic [TAG_W-1:0] tag_q,  tag_d;
   logic             hit_q,  hit_d;

   // Registered outputs
   logic              cmd_ready_q, cmd_ready_d;
   logic              rd_en_q,     rd_en_d;
   logic [SET_W-1:0]  rd_set_q,    rd_set_d;
   logic              wr_en_q,     wr_en_d;
   cache_set_t        line_out_q,  line_out_d;
   logic [1:0]        bus_op_q,    bus_op_d;
   logic              writeback_q, writeback_d;
   logic [1:0]        snoop_res_q, snoop_res_d;
   logic              cmd_done_q,  cmd_done_d;
   logic [CNT_W-1:0]  hit_cnt_q,   hit_cnt_d;
   logic [CNT_W-1:0]  miss_cnt_q,  miss_cnt_d;
   logic [CNT_W-1:0]  rd_cnt_q,    rd_cnt_d;
   logic [CNT_W-1:0]  wr_cnt_q,    wr_cnt_d;

   // Evaluation datapath
   logic             hit;
   logic [WAY_W-1:0] hit_way;
   logic             inv_found;
   logic [WAY_W-1:0] inv_way;
   logic [WAY_W-1:0] old_way;
   logic [WAY_W-1:0] victim;
   logic [WAY_W-1:0] acc_way;
   logic [LRU_W-1:0] acc_age;
   logic             victim_m;
   cache_set_t       lru_set;
   cache_set_t       ev_set;
   logic [1:0]       ev_bus_op;
   logic             ev_wb;
   logic [1:0]       ev_snoop;
   logic             ev_write;
   logic             accept;

   // Byte offset does not take part in any lookup
   logic unused_offset;
   assign unused_offset = ^bus.cmd_addr[OFF_W-1:0];

   assign accept = (state == ST_IDLE) && bus.cmd_valid && cmd_ready_q;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state logic: fixed five-step walk per command
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:  if (accept) next_state = ST_READ;
         ST_READ:  next_state = ST_EVAL;
         ST_EVAL:  next_state = ST_WRITE;
         ST_WRITE: next_state = ST_DONE;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   // Tag compare, victim choice, LRU ageing and MESI transition on the returned set
   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      old_way   = '0;
      lru_set   = bus.line_in;
      ev_set    = bus.line_in;
      ev_bus_op = BUS_NONE;
      ev_wb     = 1'b0;
      ev_snoop  = SNP_NOHIT;
      ev_write  = 1'b0;

      // Descending scans leave the lowest matching index
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (bus.line_in[w].mesi != MESI_I && bus.line_in[w].tag == tag_q) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (bus.line_in[w].mesi == MESI_I) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
         if (bus.line_in[w].lru == LRU_W'(WAYS - 1)) begin
            old_way = WAY_W'(w);
         end
      end

      victim   = inv_found ? inv_way : old_way;
      acc_way  = hit ? hit_way : victim;
      acc_age  = bus.line_in[acc_way].lru;
      victim_m = (bus.line_in[victim].mesi == MESI_M);

      for (int w = 0; w < WAYS; w++) begin
         if (WAY_W'(w) == acc_way)
            lru_set[w].lru = '0;
         else if (bus.line_in[w].lru < acc_age)
            lru_set[w].lru = bus.line_in[w].lru + LRU_W'(1);
      end

      case (cmd_q)
         CMD_RD, CMD_IFETCH: begin
            ev_write = 1'b1;
            ev_set   = lru_set;
            if (!hit) begin
               ev_bus_op          = BUS_READ;
               ev_wb              = victim_m;
               ev_set[victim].tag  = tag_q;
               ev_set[victim].mesi = bus.bus_shared ? MESI_S : MESI_E;
            end
         end
         CMD_WR: begin
            ev_write = 1'b1;
            ev_set   = lru_set;
            if (hit) begin
               if (bus.line_in[hit_way].mesi == MESI_S) ev_bus_op = BUS_INVAL;
               ev_set[hit_way].mesi = MESI_M;
            end else begin
               ev_bus_op           = BUS_RWIM;
               ev_wb               = victim_m;
               ev_set[victim].tag  = tag_q;
               ev_set[victim].mesi = MESI_M;
            end
         end
         CMD_SNP_RD: begin
            if (hit) begin
               ev_write = 1'b1;
               ev_snoop = (bus.line_in[hit_way].mesi == MESI_M) ? SNP_HITM : SNP_HIT;
               ev_set[hit_way].mesi = MESI_S;
            end
         end
         CMD_SNP_RWIM: begin
            if (hit) begin
               ev_write = 1'b1;
               ev_snoop = (bus.line_in[hit_way].mesi == MESI_M) ? SNP_HITM : SNP_HIT;
               ev_set[hit_way].mesi = MESI_I;
            end
         end
         CMD_SNP_INV: begin
            if (hit) begin
               ev_write = 1'b1;
               if (bus.line_in[hit_way].mesi == MESI_S) begin
                  ev_snoop = SNP_HIT;
                  ev_set[hit_way].mesi = MESI_I;
               end
            end
         end
         CMD_SNP_WR, CMD_CLEAR, CMD_PRINT: ev_write = 1'b0;
         default: ev_write = 1'b0;
      endcase
   end

   // Output logic: next values for every registered output and latch
   always_comb begin
      cmd_d       = cmd_q;
      tag_d       = tag_q;
      hit_d       = hit_q;
      rd_set_d    = rd_set_q;
      line_out_d  = line_out_q;
      bus_op_d    = bus_op_q;
      writeback_d = writeback_q;
      snoop_res_d = snoop_res_q;
      hit_cnt_d   = hit_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      wr_cnt_d    = wr_cnt_q;

      cmd_ready_d = (next_state == ST_IDLE);
      rd_en_d     = (next_state == ST_READ);
      cmd_done_d  = (next_state == ST_DONE);
      wr_en_d     = (state == ST_EVAL) && ev_write;

      if (accept) begin
         cmd_d    = bus.cmd_n;
         tag_d    = bus.cmd_addr[ADDR_W-1 -: TAG_W];
         rd_set_d = bus.cmd_addr[OFF_W +: SET_W];
      end

      if (state == ST_EVAL) begin
         hit_d       = hit;
         line_out_d  = ev_set;
         bus_op_d    = ev_bus_op;
         writeback_d = ev_wb;
         snoop_res_d = ev_snoop;
      end

      // Statistics settle as the command enters DONE
      if (state == ST_WRITE) begin
         case (cmd_q)
            CMD_RD, CMD_IFETCH: begin
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
               if (hit_q) hit_cnt_d  = hit_cnt_q  + CNT_W'(1);
               else       miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
            CMD_WR: begin
               wr_cnt_d = wr_cnt_q + CNT_W'(1);
               if (hit_q) hit_cnt_d  = hit_cnt_q  + CNT_W'(1);
               else       miss_cnt_d = miss_cnt_q + CNT_W'(1);
            end
            CMD_CLEAR: begin
               hit_cnt_d  = '0;
               miss_cnt_d = '0;
               rd_cnt_d   = '0;
               wr_cnt_d   = '0;
            end
            default: ;
         endcase
      end
   end

   // Output and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_q       <= '0;
         tag_q       <= '0;
         hit_q       <= 1'b0;
         cmd_ready_q <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_set_q    <= '0;
         wr_en_q     <= 1'b0;
         line_out_q  <= '0;
         bus_op_q    <= '0;
         writeback_q <= 1'b0;
         snoop_res_q <= '0;
         cmd_done_q  <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
         rd_cnt_q    <= '0;
         wr_cnt_q    <= '0;
      end else begin
         cmd_q       <= cmd_d;
         tag_q       <= tag_d;
         hit_q       <= hit_d;
         cmd_ready_q <= cmd_ready_d;
         rd_en_q     <= rd_en_d;
         rd_set_q    <= rd_set_d;
         wr_en_q     <= wr_en_d;
         line_out_q  <= line_out_d;
         bus_op_q    <= bus_op_d;
         writeback_q <= writeback_d;
         snoop_res_q <= snoop_res_d;
         cmd_done_q  <= cmd_done_d;
         hit_cnt_q   <= hit_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         wr_cnt_q    <= wr_cnt_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_set    = rd_set_q;
   assign bus.wr_en     = wr_en_q;
   assign bus.line_out  = line_out_q;
   assign bus.bus_op    = bus_op_q;
   assign bus.writeback = writeback_q;
   assign bus.snoop_res = snoop_res_q;
   assign bus.cmd_done  = cmd_done_q;
   assign bus.hit_cnt   = hit_cnt_q;
   assign bus.miss_cnt  = miss_cnt_q;
   assign bus.rd_cnt    = rd_cnt_q;
   assign bus.wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Directed bench for cache_ctrl_fsm with a synchronous-read set array model.
module tb_cache_ctrl_fsm;
   import cache_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst_n;

   cache_ctrl_if bus();

   cache_ctrl_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Observations of the most recent command, k = cycles after acceptance
   int          o_rd_k, o_wr_k, o_done_k, o_done_n;
   logic [5:0]  o_ready;
   logic [13:0] o_rd_set;
   cache_set_t  o_line;
   logic [1:0]  o_bus_op, o_snoop;
   logic        o_wb;

   // Array model: every way invalid, way w aged 7-w
   cache_set_t mem [SETS];
   initial begin
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++)
            mem[s][w] = '{mesi: MESI_I, lru: 3'(7 - w), tag: 12'h000};
      bus.line_in = '0;
      forever begin
         @(posedge clk);
         if (bus.rd_en === 1'b1) bus.line_in <= mem[bus.rd_set];
         if (bus.wr_en === 1'b1) mem[bus.rd_set] <= bus.line_out;
      end
   end

   function automatic cache_line_t mk(input mesi_t m, input logic [2:0] a, input logic [11:0] t);
      mk = '{mesi: m, lru: a, tag: t};
   endfunction

   function automatic logic [31:0] adr(input logic [11:0] t, input logic [13:0] s);
      adr = {t, s, 6'd0};
   endfunction

   task automatic run_cmd(input logic [3:0] c, input logic [31:0] a);
      int guard = 0;
      o_rd_k = 0; o_wr_k = 0; o_done_k = 0; o_done_n = 0;
      o_ready = '0; o_rd_set = '0; o_line = '0;
      o_bus_op = '0; o_wb = 1'b0; o_snoop = '0;
      while (bus.cmd_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (bus.cmd_ready !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL ready_wait: cmd_ready=%b after 20 cycles, required 1", bus.cmd_ready);
         return;
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_n     = c;
      bus.cmd_addr  = a;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) @(negedge clk);
         o_ready[k-1] = bus.cmd_ready;
         if (bus.rd_en === 1'b1 && o_rd_k == 0) begin o_rd_k = k; o_rd_set = bus.rd_set; end
         if (bus.wr_en === 1'b1) begin if (o_wr_k == 0) o_wr_k = k; o_line = bus.line_out; end
         if (bus.cmd_done === 1'b1) begin
            o_done_n++;
            if (o_done_k == 0) o_done_k = k;
            o_bus_op = bus.bus_op; o_wb = bus.writeback; o_snoop = bus.snoop_res;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_n = '0; bus.cmd_addr = '0; bus.bus_shared = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if ({bus.cmd_ready, bus.rd_en, bus.wr_en, bus.cmd_done} !== 4'b0) begin n_bad++;
         $display("FAIL reset_ctrl: ready/rd/wr/done=%b required 0000", {bus.cmd_ready, bus.rd_en, bus.wr_en, bus.cmd_done}); end
      n_cmp++; if ({bus.hit_cnt, bus.miss_cnt, bus.rd_cnt, bus.wr_cnt} !== 128'd0) begin n_bad++;
         $display("FAIL reset_cnt: counters=%h required 0", {bus.hit_cnt, bus.miss_cnt, bus.rd_cnt, bus.wr_cnt}); end
      n_cmp++; if (bus.line_out !== '0 || bus.bus_op !== 2'd0 || bus.snoop_res !== 2'd0) begin n_bad++;
         $display("FAIL reset_line: line_out=%h bus_op=%0d snoop=%0d required 0", bus.line_out, bus.bus_op, bus.snoop_res); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++;
         $display("FAIL reset_release_ready: cmd_ready=%b required 1", bus.cmd_ready); end
   endtask

   task automatic test_read_miss();
      run_cmd(CMD_RD, 32'h0040_0040);
      n_cmp++; if (o_rd_k !== 1 || o_rd_set !== 14'd1) begin n_bad++;
         $display("FAIL rmiss_read: rd_k=%0d set=%0d required 1/1", o_rd_k, o_rd_set); end
      n_cmp++; if (o_wr_k !== 3 || o_done_k !== 4 || o_done_n !== 1) begin n_bad++;
         $display("FAIL rmiss_timing: wr_k=%0d done_k=%0d pulses=%0d required 3/4/1", o_wr_k, o_done_k, o_done_n); end
      n_cmp++; if (o_bus_op !== BUS_READ || o_wb !== 1'b0) begin n_bad++;
         $display("FAIL rmiss_bus: bus_op=%0d wb=%b required 1/0", o_bus_op, o_wb); end
      n_cmp++; if (o_line[0] !== mk(MESI_E, 3'd0, 12'h004) || o_line[1] !== mk(MESI_I, 3'd7, 12'h0)
                   || o_line[7] !== mk(MESI_I, 3'd1, 12'h0)) begin n_bad++;
         $display("FAIL rmiss_line: w0=%h w1=%h w7=%h required %h %h %h", o_line[0], o_line[1], o_line[7],
                  mk(MESI_E, 3'd0, 12'h004), mk(MESI_I, 3'd7, 12'h0), mk(MESI_I, 3'd1, 12'h0)); end
      n_cmp++; if (bus.miss_cnt !== 32'd1 || bus.rd_cnt !== 32'd1 || bus.hit_cnt !== 32'd0) begin n_bad++;
         $display("FAIL rmiss_cnt: miss=%0d rd=%0d hit=%0d required 1/1/0", bus.miss_cnt, bus.rd_cnt, bus.hit_cnt); end
   endtask

   task automatic test_read_hit();
      run_cmd(CMD_RD, 32'h0040_0040);
      n_cmp++; if (o_bus_op !== BUS_NONE || o_line[0] !== mk(MESI_E, 3'd0, 12'h004) || o_line[1] !== mk(MESI_I, 3'd7, 12'h0)) begin n_bad++;
         $display("FAIL rhit: bus_op=%0d w0=%h w1=%h required 0 %h %h", o_bus_op, o_line[0], o_line[1],
                  mk(MESI_E, 3'd0, 12'h004), mk(MESI_I, 3'd7, 12'h0)); end
      n_cmp++; if (bus.hit_cnt !== 32'd1 || bus.rd_cnt !== 32'd2 || bus.miss_cnt !== 32'd1) begin n_bad++;
         $display("FAIL rhit_cnt: hit=%0d rd=%0d miss=%0d required 1/2/1", bus.hit_cnt, bus.rd_cnt, bus.miss_cnt); end
   endtask

   task automatic test_write_hit();
      run_cmd(CMD_WR, 32'h0040_0040);
      n_cmp++; if (o_bus_op !== BUS_NONE || o_line[0] !== mk(MESI_M, 3'd0, 12'h004)) begin n_bad++;
         $display("FAIL whit_e: bus_op=%0d w0=%h required 0 %h", o_bus_op, o_line[0], mk(MESI_M, 3'd0, 12'h004)); end
      n_cmp++; if (bus.hit_cnt !== 32'd2 || bus.wr_cnt !== 32'd1) begin n_bad++;
         $display("FAIL whit_cnt: hit=%0d wr=%0d required 2/1", bus.hit_cnt, bus.wr_cnt); end
   endtask

   task automatic test_snoop_read();
      run_cmd(CMD_SNP_RD, 32'h0040_0040);
      n_cmp++; if (o_snoop !== SNP_HITM || o_bus_op !== BUS_NONE || o_wr_k !== 3) begin n_bad++;
         $display("FAIL snprd_res: snoop=%0d bus_op=%0d wr_k=%0d required 2/0/3", o_snoop, o_bus_op, o_wr_k); end
      n_cmp++; if (o_line[0] !== mk(MESI_S, 3'd0, 12'h004) || o_line[1] !== mk(MESI_I, 3'd7, 12'h0)) begin n_bad++;
         $display("FAIL snprd_line: w0=%h w1=%h required %h %h", o_line[0], o_line[1],
                  mk(MESI_S, 3'd0, 12'h004), mk(MESI_I, 3'd7, 12'h0)); end
      n_cmp++; if (bus.hit_cnt !== 32'd2 || bus.miss_cnt !== 32'd1) begin n_bad++;
         $display("FAIL snprd_cnt: hit=%0d miss=%0d required 2/1", bus.hit_cnt, bus.miss_cnt); end
   endtask

   task automatic test_fill_evict();
      // Shared line written: upgrade needs an invalidate on the bus
      run_cmd(CMD_WR, 32'h0040_0040);
      n_cmp++; if (o_bus_op !== BUS_INVAL || o_line[0] !== mk(MESI_M, 3'd0, 12'h004)) begin n_bad++;
         $display("FAIL whit_s: bus_op=%0d w0=%h required 3 %h", o_bus_op, o_line[0], mk(MESI_M, 3'd0, 12'h004)); end
      bus.bus_shared = 1'b1;
      for (int i = 0; i < 7; i++) begin
         run_cmd(CMD_RD, adr(12'(12'h005 + i), 14'd1));
         n_cmp++; if (o_bus_op !== BUS_READ || o_wb !== 1'b0 || o_line[i+1] !== mk(MESI_S, 3'd0, 12'(12'h005 + i))) begin n_bad++;
            $display("FAIL fill_%0d: bus_op=%0d wb=%b way=%h required 1/0 %h", i, o_bus_op, o_wb, o_line[i+1],
                     mk(MESI_S, 3'd0, 12'(12'h005 + i))); end
      end
      bus.bus_shared = 1'b0;
      run_cmd(CMD_RD, adr(12'h00C, 14'd1));
      n_cmp++; if (o_bus_op !== BUS_READ || o_wb !== 1'b1) begin n_bad++;
         $display("FAIL evict_bus: bus_op=%0d wb=%b required 1/1", o_bus_op, o_wb); end
      n_cmp++; if (o_line[0] !== mk(MESI_E, 3'd0, 12'h00C) || o_line[1] !== mk(MESI_S, 3'd7, 12'h005)
                   || o_line[7] !== mk(MESI_S, 3'd1, 12'h00B)) begin n_bad++;
         $display("FAIL evict_line: w0=%h w1=%h w7=%h required %h %h %h", o_line[0], o_line[1], o_line[7],
                  mk(MESI_E, 3'd0, 12'h00C), mk(MESI_S, 3'd7, 12'h005), mk(MESI_S, 3'd1, 12'h00B)); end
      n_cmp++; if (bus.miss_cnt !== 32'd9 || bus.rd_cnt !== 32'd10 || bus.hit_cnt !== 32'd3 || bus.wr_cnt !== 32'd2) begin n_bad++;
         $display("FAIL evict_cnt: miss=%0d rd=%0d hit=%0d wr=%0d required 9/10/3/2", bus.miss_cnt, bus.rd_cnt, bus.hit_cnt, bus.wr_cnt); end
   endtask

   task automatic test_snoops();
      run_cmd(CMD_SNP_RWIM, adr(12'h005, 14'd1));
      n_cmp++; if (o_snoop !== SNP_HIT || o_line[1] !== mk(MESI_I, 3'd7, 12'h005)) begin n_bad++;
         $display("FAIL rwim_s: snoop=%0d w1=%h required 1 %h", o_snoop, o_line[1], mk(MESI_I, 3'd7, 12'h005)); end
      run_cmd(CMD_SNP_INV, adr(12'h006, 14'd1));
      n_cmp++; if (o_snoop !== SNP_HIT || o_line[2] !== mk(MESI_I, 3'd6, 12'h006)) begin n_bad++;
         $display("FAIL inv_s: snoop=%0d w2=%h required 1 %h", o_snoop, o_line[2], mk(MESI_I, 3'd6, 12'h006)); end
      run_cmd(CMD_SNP_INV, adr(12'h00C, 14'd1));
      n_cmp++; if (o_snoop !== SNP_NOHIT || o_line[0] !== mk(MESI_E, 3'd0, 12'h00C)) begin n_bad++;
         $display("FAIL inv_e: snoop=%0d w0=%h required 0 %h", o_snoop, o_line[0], mk(MESI_E, 3'd0, 12'h00C)); end
      run_cmd(CMD_SNP_RD, adr(12'h0FF, 14'd1));
      n_cmp++; if (o_snoop !== SNP_NOHIT || o_wr_k !== 0 || o_done_k !== 4) begin n_bad++;
         $display("FAIL snp_miss: snoop=%0d wr_k=%0d done_k=%0d required 0/0/4", o_snoop, o_wr_k, o_done_k); end
      run_cmd(CMD_SNP_WR, adr(12'h00C, 14'd1));
      n_cmp++; if (o_wr_k !== 0 || o_done_k !== 4) begin n_bad++;
         $display("FAIL snp_wr: wr_k=%0d done_k=%0d required 0/4", o_wr_k, o_done_k); end
      run_cmd(CMD_WR, adr(12'h00C, 14'd1));
      n_cmp++; if (o_bus_op !== BUS_NONE || o_line[0] !== mk(MESI_M, 3'd0, 12'h00C)) begin n_bad++;
         $display("FAIL whit_e2: bus_op=%0d w0=%h required 0 %h", o_bus_op, o_line[0], mk(MESI_M, 3'd0, 12'h00C)); end
      run_cmd(CMD_SNP_RWIM, adr(12'h00C, 14'd1));
      n_cmp++; if (o_snoop !== SNP_HITM || o_line[0] !== mk(MESI_I, 3'd0, 12'h00C)) begin n_bad++;
         $display("FAIL rwim_m: snoop=%0d w0=%h required 2 %h", o_snoop, o_line[0], mk(MESI_I, 3'd0, 12'h00C)); end
      n_cmp++; if (bus.hit_cnt !== 32'd4 || bus.wr_cnt !== 32'd3 || bus.miss_cnt !== 32'd9 || bus.rd_cnt !== 32'd10) begin n_bad++;
         $display("FAIL snp_cnt: hit=%0d wr=%0d miss=%0d rd=%0d required 4/3/9/10", bus.hit_cnt, bus.wr_cnt, bus.miss_cnt, bus.rd_cnt); end
   endtask

   task automatic test_write_miss();
      run_cmd(CMD_WR, 32'h1230_0080);
      n_cmp++; if (o_rd_set !== 14'd2 || o_bus_op !== BUS_RWIM || o_wb !== 1'b0) begin n_bad++;
         $display("FAIL wmiss_bus: set=%0d bus_op=%0d wb=%b required 2/2/0", o_rd_set, o_bus_op, o_wb); end
      n_cmp++; if (o_line[0] !== mk(MESI_M, 3'd0, 12'h123) || o_line[1] !== mk(MESI_I, 3'd7, 12'h0)) begin n_bad++;
         $display("FAIL wmiss_line: w0=%h w1=%h required %h %h", o_line[0], o_line[1], mk(MESI_M, 3'd0, 12'h123), mk(MESI_I, 3'd7, 12'h0)); end
      n_cmp++; if (bus.miss_cnt !== 32'd10 || bus.wr_cnt !== 32'd4) begin n_bad++;
         $display("FAIL wmiss_cnt: miss=%0d wr=%0d required 10/4", bus.miss_cnt, bus.wr_cnt); end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      while (bus.cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
      bus.cmd_valid = 1'b1; bus.cmd_n = CMD_RD; bus.cmd_addr = 32'h0AB0_00C0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.wr_en !== 1'b0 || bus.cmd_done !== 1'b0) begin n_bad++;
         $display("FAIL rstmid_wr: wr_en=%b done=%b required 0/0", bus.wr_en, bus.cmd_done); end
      @(negedge clk);
      n_cmp++; if ({bus.hit_cnt, bus.miss_cnt, bus.rd_cnt, bus.wr_cnt} !== 128'd0 || bus.cmd_ready !== 1'b0 || bus.cmd_done !== 1'b0) begin n_bad++;
         $display("FAIL rstmid_state: cnts=%h ready=%b done=%b required 0/0/0", {bus.hit_cnt, bus.miss_cnt, bus.rd_cnt, bus.wr_cnt}, bus.cmd_ready, bus.cmd_done); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++;
         $display("FAIL rstmid_ready: cmd_ready=%b required 1", bus.cmd_ready); end
      // Abandoned command must not have touched the array
      run_cmd(CMD_RD, 32'h0AB0_00C0);
      n_cmp++; if (o_bus_op !== BUS_READ || o_line[0] !== mk(MESI_E, 3'd0, 12'h0AB) || bus.miss_cnt !== 32'd1 || bus.rd_cnt !== 32'd1) begin n_bad++;
         $display("FAIL rstmid_after: bus_op=%0d w0=%h miss=%0d rd=%0d required 1 %h 1 1", o_bus_op, o_line[0], bus.miss_cnt, bus.rd_cnt,
                  mk(MESI_E, 3'd0, 12'h0AB)); end
   endtask

   task automatic test_print_clear();
      run_cmd(CMD_PRINT, 32'h0AB0_00C0);
      n_cmp++; if (o_wr_k !== 0 || o_done_k !== 4 || bus.miss_cnt !== 32'd1 || bus.rd_cnt !== 32'd1) begin n_bad++;
         $display("FAIL print: wr_k=%0d done_k=%0d miss=%0d rd=%0d required 0/4/1/1", o_wr_k, o_done_k, bus.miss_cnt, bus.rd_cnt); end
      run_cmd(4'd7, 32'h0AB0_00C0);
      n_cmp++; if (o_wr_k !== 0 || o_done_k !== 4) begin n_bad++;
         $display("FAIL undef_cmd: wr_k=%0d done_k=%0d required 0/4", o_wr_k, o_done_k); end
      run_cmd(CMD_CLEAR, 32'h0);
      n_cmp++; if (o_wr_k !== 0 || {bus.hit_cnt, bus.miss_cnt, bus.rd_cnt, bus.wr_cnt} !== 128'd0) begin n_bad++;
         $display("FAIL clear: wr_k=%0d cnts=%h required 0/0", o_wr_k, {bus.hit_cnt, bus.miss_cnt, bus.rd_cnt, bus.wr_cnt}); end
   endtask

   task automatic test_back_to_back();
      run_cmd(CMD_RD, 32'h0AB0_00C0);
      n_cmp++; if (o_ready !== 6'b110000 || o_done_n !== 1) begin n_bad++;
         $display("FAIL b2b_ready1: ready=%b pulses=%0d required 110000/1", o_ready, o_done_n); end
      run_cmd(CMD_IFETCH, 32'h0AB0_00C0);
      n_cmp++; if (o_ready !== 6'b110000 || o_done_k !== 4 || o_bus_op !== BUS_NONE) begin n_bad++;
         $display("FAIL b2b_ready2: ready=%b done_k=%0d bus_op=%0d required 110000/4/0", o_ready, o_done_k, o_bus_op); end
      n_cmp++; if (bus.hit_cnt !== 32'd2 || bus.rd_cnt !== 32'd2 || bus.miss_cnt !== 32'd0) begin n_bad++;
         $display("FAIL b2b_cnt: hit=%0d rd=%0d miss=%0d required 2/2/0", bus.hit_cnt, bus.rd_cnt, bus.miss_cnt); end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_hit();
      test_snoop_read();
      test_fill_evict();
      test_snoops();
      test_write_miss();
      test_reset_mid();
      test_print_clear();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
